// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver: FSM states, frame geometry, byte packing order.
// Pure declarations; no logic, no latency, no backpressure.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int BYTE_W           = 8;
   localparam int STOP_BITS        = 1;
   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int WORD_W           = 2 * BYTE_W;
   localparam bit LOW_BYTE_FIRST   = 1'b1;

   // First byte off the wire lands in the low half when LOW_BYTE_FIRST is set.
   function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] first,
                                                   input logic [BYTE_W-1:0] second);
      return LOW_BYTE_FIRST ? {second, first} : {first, second};
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, baud counter and frame FSM; byte_valid/byte_err pulse one cycle after mid-stop.
// No backpressure: each pulse lasts one cycle and must be consumed immediately.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [BYTE_W-1:0] rx_byte,
   output logic              byte_valid,
   output logic              byte_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(BYTE_W - 1);

   logic              rx_meta, rx_s;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [BYTE_W-1:0] shreg_q, shreg_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign tick = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = HALF_LOAD;
               bit_d   = '0;
            end
         end
         START: begin
            if (tick) begin
               // A start bit that has gone high again by mid-bit is line noise.
               if (!rx_s) begin
                  state_d = DATA;
                  cnt_d   = FULL_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_d = {rx_s, shreg_q[BYTE_W-1:1]};
               cnt_d   = FULL_LOAD;
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = STOP;
                  cnt_d   = STOP_LOAD;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves half a bit of slack for back-to-back frames.
            if (tick) begin
               state_d = IDLE;
               valid_d = rx_s;
               err_d   = !rx_s;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_byte    = shreg_q;
   assign byte_valid = valid_q;
   assign byte_err   = err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Pairs received UART bytes into 16-bit words; write_en pulses one cycle after the second byte's valid pulse.
// No backpressure: the downstream register must accept every write_en pulse; a framing error drops any half word.
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [WORD_W-1:0] data_out,
   output logic              write_en,
   output logic              frame_err,
   output logic              busy,
   output logic              half_word
);

   logic [BYTE_W-1:0] rx_byte;
   logic              byte_valid;
   logic              byte_err;
   logic [BYTE_W-1:0] low_q;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_byte (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .byte_err  (byte_err),
      .busy      (busy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         write_en  <= 1'b0;
         half_word <= 1'b0;
         low_q     <= '0;
      end else begin
         write_en <= 1'b0;
         if (byte_err) begin
            half_word <= 1'b0;
         end else if (byte_valid) begin
            if (!half_word) begin
               low_q     <= rx_byte;
               half_word <= 1'b1;
            end else begin
               data_out  <= pack_word(low_q, rx_byte);
               write_en  <= 1'b1;
               half_word <= 1'b0;
            end
         end
      end
   end

   assign frame_err = byte_err;

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word at 16 clocks per bit: directed frames, monitor pops expected words on write_en.
module tb_uart_rx_word;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [15:0] data_out;
   logic        write_en;
   logic        frame_err;
   logic        busy;
   logic        half_word;

   logic [15:0] exp_q[$];
   logic [15:0] reg_q;
   int          checks    = 0;
   int          errors    = 0;
   int          wr_cnt    = 0;
   int          ferr_cnt  = 0;
   int          busy_run  = 0;
   int          max_busy  = 0;

   always #5 clk = ~clk;

   uart_rx_word #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data_out (data_out),
      .write_en (write_en),
      .frame_err(frame_err),
      .busy     (busy),
      .half_word(half_word)
   );

   // Downstream 16-bit storage register fed by the receiver.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) reg_q <= '0;
      else if (write_en) reg_q <= data_out;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cycles(CPB);
      end
      rx = stop_bit;
      cycles(CPB);
      rx = 1'b1;
   endtask

   initial begin
      logic [15:0] exp_w;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_run = 0;
         end else begin
            if (write_en) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got 0x%0h expected no write", data_out);
               end else begin
                  exp_w = exp_q.pop_front();
                  chk("write_data", 32'(data_out), 32'(exp_w));
               end
            end
            if (frame_err) ferr_cnt++;
            busy_run = busy ? busy_run + 1 : 0;
            if (busy_run > max_busy) max_busy = busy_run;
         end
      end
   end

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      cycles(5);
      chk("reset_outputs", 32'({data_out, write_en, frame_err, busy, half_word}), 32'h0);
      rst = 1'b0;
      cycles(400);
      chk("idle_no_write", wr_cnt, 0);
      chk("idle_no_ferr", ferr_cnt, 0);
      chk("idle_no_busy", max_busy, 0);
      chk("idle_outputs", 32'({data_out, write_en, frame_err, busy, half_word}), 32'h0);

      // Single word, back-to-back bytes
      send_byte(8'h0F, 1'b1);
      chk("half_after_first", 32'(half_word), 32'd1);
      chk("no_write_first_byte", wr_cnt, 0);
      exp_q.push_back(16'h000F);
      send_byte(8'h00, 1'b1);
      cycles(8);
      chk("one_write", wr_cnt, 1);
      chk("downstream_reg", 32'(reg_q), 32'd15);
      chk("half_cleared", 32'(half_word), 32'd0);

      // Byte ordering and hold between writes
      exp_q.push_back(16'h1234);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      cycles(8);
      exp_q.push_back(16'hABCD);
      send_byte(8'hCD, 1'b1);
      chk("hold_between", 32'(data_out), 32'h1234);
      send_byte(8'hAB, 1'b1);
      cycles(8);
      chk("writes_after_order", wr_cnt, 3);

      // Framing error discards half-built word
      send_byte(8'h55, 1'b1);
      chk("half_before_err", 32'(half_word), 32'd1);
      send_byte(8'hAA, 1'b0);
      cycles(32);
      chk("ferr_count", ferr_cnt, 1);
      chk("half_after_err", 32'(half_word), 32'd0);
      chk("data_kept_on_err", 32'(data_out), 32'hABCD);
      exp_q.push_back(16'h2211);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      cycles(8);
      chk("writes_after_err", wr_cnt, 4);
      chk("ferr_single", ferr_cnt, 1);

      // Start-bit glitch
      max_busy = 0;
      rx = 1'b0;
      cycles(4);
      rx = 1'b1;
      cycles(40);
      checks++;
      if (max_busy < 1 || max_busy > 10) begin
         errors++;
         $display("FAIL glitch_busy: got %0d cycles expected 1..10", max_busy);
      end
      chk("glitch_idle", 32'(busy), 32'd0);
      chk("glitch_no_ferr", ferr_cnt, 1);
      chk("glitch_no_write", wr_cnt, 4);

      // Reset during second byte's data bits
      send_byte(8'h5A, 1'b1);
      chk("half_before_rst", 32'(half_word), 32'd1);
      rx = 1'b0;
      cycles(CPB * 3);
      rst = 1'b1;
      rx  = 1'b1;
      cycles(5);
      rst = 1'b0;
      cycles(40);
      chk("rst_half", 32'(half_word), 32'd0);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_no_write", wr_cnt, 4);
      exp_q.push_back(16'h5678);
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      cycles(8);
      chk("writes_after_rst", wr_cnt, 5);
      chk("downstream_after_rst", 32'(reg_q), 32'h5678);

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
